// File: rtl/chimera_route_pkg.sv
// Shared types and width helpers for the wide-master routing controller.
package chimera_route_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    function automatic int sel_width(input int num_rules);
        return (num_rules < 1) ? 1 : $clog2(num_rules + 1);
    endfunction

    function automatic int cnt_width(input int max_trans);
        return $clog2(max_trans + 1);
    endfunction

endpackage

// File: rtl/chimera_txn_counter.sv
// Outstanding-transaction counter: saturates at 0, flags decrements with nothing outstanding.
module chimera_txn_counter
    import chimera_route_pkg::*;
#(
    parameter int  MaxTrans = 16,
    localparam int CntW     = cnt_width(MaxTrans)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] cnt_o,
    output logic            full_o,
    output logic            underflow_o
);

    logic [CntW-1:0] cnt_reg;

    assign full_o      = (cnt_reg == CntW'(MaxTrans));
    assign underflow_o = dec_i & ~inc_i & (cnt_reg == '0);
    assign cnt_o       = cnt_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else if (inc_i && !dec_i && !full_o) begin
            cnt_reg <= cnt_reg + CntW'(1);
        end else if (dec_i && !inc_i && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CntW'(1);
        end
    end

endmodule

// File: rtl/chimera_wide_route_ctrl.sv
// Wide AXI master routing controller: region decode, outstanding-transaction gating and
// drain-before-switch handling of the bypass mode.
module chimera_wide_route_ctrl
    import chimera_route_pkg::*;
#(
    parameter int  NumRules  = 2,
    parameter int  AddrWidth = 48,
    parameter int  MaxTrans  = 16,
    parameter bit  BypassRst = 1'b0,
    localparam int SelW      = sel_width(NumRules),
    localparam int CntW      = cnt_width(MaxTrans)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumRules-1:0][AddrWidth-1:0] rule_start_i,
    input  logic [NumRules-1:0][AddrWidth-1:0] rule_end_i,
    input  logic                               bypass_req_i,
    input  logic                               aw_valid_i,
    output logic                               aw_ready_o,
    input  logic [AddrWidth-1:0]               aw_addr_i,
    output logic                               aw_valid_o,
    input  logic                               aw_ready_i,
    output logic [SelW-1:0]                    aw_sel_o,
    input  logic                               ar_valid_i,
    output logic                               ar_ready_o,
    input  logic [AddrWidth-1:0]               ar_addr_i,
    output logic                               ar_valid_o,
    input  logic                               ar_ready_i,
    output logic [SelW-1:0]                    ar_sel_o,
    input  logic                               b_valid_i,
    input  logic                               b_ready_i,
    input  logic                               r_valid_i,
    input  logic                               r_ready_i,
    input  logic                               r_last_i,
    output logic                               bypass_o,
    output logic                               draining_o,
    output logic [CntW-1:0]                    w_outst_o,
    output logic [CntW-1:0]                    r_outst_o,
    output logic                               err_o
);

    state_e          state_reg, state_next;
    logic            bypass_reg, bypass_next;
    logic            aw_pend_reg, ar_pend_reg;
    logic [SelW-1:0] aw_sel_reg, ar_sel_reg;
    logic            err_reg;

    logic [NumRules-1:0] aw_hit, ar_hit;
    logic [SelW-1:0]     aw_sel_dec, ar_sel_dec;
    logic                w_full, r_full, w_uflow, r_uflow;
    logic                aw_open, ar_open, drained;

    // A rule with end <= start never matches, which is how regions are disabled.
    for (genvar gi = 0; gi < NumRules; gi++) begin : g_rule
        logic rule_en;
        assign rule_en     = rule_end_i[gi] > rule_start_i[gi];
        assign aw_hit[gi]  = rule_en && (aw_addr_i >= rule_start_i[gi]) && (aw_addr_i < rule_end_i[gi]);
        assign ar_hit[gi]  = rule_en && (ar_addr_i >= rule_start_i[gi]) && (ar_addr_i < rule_end_i[gi]);
    end

    function automatic logic [SelW-1:0] pick_port(input logic [NumRules-1:0] hit);
        pick_port = '0;
        for (int i = NumRules - 1; i >= 0; i--) begin
            if (hit[i]) pick_port = SelW'(i + 1);
        end
    endfunction

    assign aw_sel_dec = bypass_reg ? '0 : pick_port(aw_hit);
    assign ar_sel_dec = bypass_reg ? '0 : pick_port(ar_hit);

    // A request already presented downstream stays open so valid and select never retract.
    assign aw_open    = aw_pend_reg | ((state_reg == RUN) & ~w_full);
    assign ar_open    = ar_pend_reg | ((state_reg == RUN) & ~r_full);
    assign aw_valid_o = aw_valid_i & aw_open;
    assign aw_ready_o = aw_ready_i & aw_open;
    assign ar_valid_o = ar_valid_i & ar_open;
    assign ar_ready_o = ar_ready_i & ar_open;
    assign aw_sel_o   = aw_pend_reg ? aw_sel_reg : aw_sel_dec;
    assign ar_sel_o   = ar_pend_reg ? ar_sel_reg : ar_sel_dec;

    chimera_txn_counter #(.MaxTrans(MaxTrans)) u_w_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_i       (aw_valid_o & aw_ready_i),
        .dec_i       (b_valid_i & b_ready_i),
        .cnt_o       (w_outst_o),
        .full_o      (w_full),
        .underflow_o (w_uflow)
    );

    chimera_txn_counter #(.MaxTrans(MaxTrans)) u_r_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_i       (ar_valid_o & ar_ready_i),
        .dec_i       (r_valid_i & r_ready_i & r_last_i),
        .cnt_o       (r_outst_o),
        .full_o      (r_full),
        .underflow_o (r_uflow)
    );

    assign drained = (w_outst_o == '0) && (r_outst_o == '0) && !aw_pend_reg && !ar_pend_reg;

    always_comb begin
        state_next  = state_reg;
        bypass_next = bypass_reg;
        case (state_reg)
            RUN: begin
                if (bypass_req_i != bypass_reg) state_next = DRAIN;
            end
            DRAIN: begin
                if (drained) begin
                    state_next  = RUN;
                    bypass_next = bypass_req_i;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= RUN;
            bypass_reg  <= BypassRst;
            aw_pend_reg <= 1'b0;
            ar_pend_reg <= 1'b0;
            aw_sel_reg  <= '0;
            ar_sel_reg  <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bypass_reg  <= bypass_next;
            aw_pend_reg <= aw_valid_o & ~aw_ready_i;
            ar_pend_reg <= ar_valid_o & ~ar_ready_i;
            if (aw_valid_o && !aw_ready_i && !aw_pend_reg) aw_sel_reg <= aw_sel_dec;
            if (ar_valid_o && !ar_ready_i && !ar_pend_reg) ar_sel_reg <= ar_sel_dec;
            err_reg     <= err_reg | w_uflow | r_uflow;
        end
    end

    assign bypass_o   = bypass_reg;
    assign draining_o = (state_reg == DRAIN);
    assign err_o      = err_reg;

endmodule
